// File: rtl/freg_wb_scheduler_pkg.sv
// Shared FP-writeback definitions.
//   XLEN         : FP register count and data width
//   f_register_e : FP register name (f0..f31)
//   float_t      : single-precision raw bit pattern
//   N_FWB_REQ    : default number of FP writeback requesters
//   fwb_req_t    : one writeback request {valid, faddr, data}
package freg_wb_scheduler_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned FADDR_W   = 5;
  localparam int unsigned N_FWB_REQ = 4;

  typedef enum logic [FADDR_W-1:0] {
    F0,  F1,  F2,  F3,  F4,  F5,  F6,  F7,
    F8,  F9,  F10, F11, F12, F13, F14, F15,
    F16, F17, F18, F19, F20, F21, F22, F23,
    F24, F25, F26, F27, F28, F29, F30, F31
  } f_register_e;

  typedef logic [XLEN-1:0] float_t;

  typedef struct packed {
    logic        valid;
    f_register_e faddr;
    float_t      data;
  } fwb_req_t;

endpackage

// File: rtl/freg_wb_scheduler_if.sv
// FP writeback request bus: N_REQ valid/ready channels, each carrying a
// destination register and a result.
//   req_valid : per-requester request (master -> slave)
//   req_faddr : per-requester destination register (master -> slave)
//   req_data  : per-requester result (master -> slave)
//   req_ready : per-requester grant (slave -> master)
interface freg_wb_scheduler_if
  import freg_wb_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = N_FWB_REQ
);

  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ-1:0][FADDR_W-1:0] req_faddr;
  logic [N_REQ-1:0][XLEN-1:0]    req_data;
  logic [N_REQ-1:0]              req_ready;

  modport master (
    output req_valid, req_faddr, req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_faddr, req_data,
    output req_ready
  );

endinterface

// File: rtl/freg_rr_arbiter.sv
// N-way round-robin arbiter with internal priority pointer.
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : grants are issued and the pointer moves only when high
//   req_i        : request vector
//   gnt_o        : one-hot grant (zero when nothing is granted)
//   gnt_idx_o    : index of the granted requester
//   gnt_valid_o  : a grant is issued this cycle
// A grant always completes a transfer, so the pointer advances past the
// winner whenever gnt_valid_o is high.
module freg_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 gnt_valid_o
);

  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned idx;
    logic        found;
    // NOTE: every variable assigned here gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    found       = 1'b0;
    ptr_d       = ptr_q;

    // Scan from the pointer upward, wrapping modulo N (N need not be 2^k).
    for (int unsigned off = 0; off < N; off++) begin
      idx = {{(32-PW){1'b0}}, ptr_q} + off;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        found     = 1'b1;
        gnt_idx_o = idx[PW-1:0];
      end
    end

    gnt_valid_o      = found & en_i;
    gnt_o[gnt_idx_o] = gnt_valid_o;

    if (gnt_valid_o) begin
      if (gnt_idx_o == PW'(N - 1)) ptr_d = '0;
      else                         ptr_d = gnt_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/freg_wb_scheduler.sv
// FP register-file writeback scheduler.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clk_en_i       : global enable; all state frozen while low
//   issue_valid_i  : an FP-writing instruction issues to issue_faddr_i
//   issue_ready_o  : destination not pending (WAW stall otherwise)
//   wb             : writeback request bus (slave side)
//   we_o, w_faddr_o, wr_fdata_o : registered register-file write port
//   r_faddr_i, r_used_i         : source operands of the decoding instruction
//   hazard_o       : a used source register has a write in flight
//   pending_o      : per-register in-flight scoreboard
module freg_wb_scheduler
  import freg_wb_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = N_FWB_REQ
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clk_en_i,
  input  logic                    issue_valid_i,
  input  f_register_e             issue_faddr_i,
  output logic                    issue_ready_o,
  freg_wb_scheduler_if.slave      wb,
  output logic                    we_o,
  output f_register_e             w_faddr_o,
  output float_t                  wr_fdata_o,
  input  logic [2:0][FADDR_W-1:0] r_faddr_i,
  input  logic [2:0]              r_used_i,
  output logic                    hazard_o,
  output logic [XLEN-1:0]         pending_o
);

  logic [$clog2(N_REQ)-1:0] gnt_idx;
  logic                     gnt_valid;
  fwb_req_t                 sel_req;

  logic [XLEN-1:0] pending_q, pending_d;
  logic            we_q, we_d;
  f_register_e     w_faddr_q, w_faddr_d;
  float_t          wr_fdata_q, wr_fdata_d;
  logic            issue_fire;

  freg_rr_arbiter #(.N(N_REQ)) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (clk_en_i),
    .req_i       (wb.req_valid),
    .gnt_o       (wb.req_ready),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  assign issue_ready_o = ~pending_q[issue_faddr_i];
  assign issue_fire    = clk_en_i & issue_valid_i & issue_ready_o;

  always_comb begin
    sel_req.valid = gnt_valid;
    sel_req.faddr = f_register_e'(wb.req_faddr[gnt_idx]);
    sel_req.data  = wb.req_data[gnt_idx];

    pending_d  = pending_q;
    we_d       = we_q;
    w_faddr_d  = w_faddr_q;
    wr_fdata_d = wr_fdata_q;

    if (clk_en_i) begin
      // Retire the write currently on the port, then apply a new issue so
      // that a set to the same register takes precedence.
      if (we_q)       pending_d[w_faddr_q]     = 1'b0;
      if (issue_fire) pending_d[issue_faddr_i] = 1'b1;

      we_d = sel_req.valid;
      if (sel_req.valid) begin
        w_faddr_d  = sel_req.faddr;
        wr_fdata_d = sel_req.data;
      end
    end
  end

  always_comb begin
    hazard_o = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (r_used_i[p] && pending_q[r_faddr_i[p]]) hazard_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the scoreboard is a flop vector, not RAM, so it resets in one
      // cycle; the write port resets too so no stale write survives reset.
      pending_q  <= '0;
      we_q       <= 1'b0;
      w_faddr_q  <= F0;
      wr_fdata_q <= '0;
    end else begin
      pending_q  <= pending_d;
      we_q       <= we_d;
      w_faddr_q  <= w_faddr_d;
      wr_fdata_q <= wr_fdata_d;
    end
  end

  assign we_o       = we_q;
  assign w_faddr_o  = w_faddr_q;
  assign wr_fdata_o = wr_fdata_q;
  assign pending_o  = pending_q;

endmodule

// File: tb/tb_freg_wb_scheduler.sv
module tb_freg_wb_scheduler;
  import freg_wb_scheduler_pkg::*;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              clk_en;
  logic              issue_valid;
  f_register_e       issue_faddr;
  logic              issue_ready;
  logic              we;
  f_register_e       w_faddr;
  float_t            wr_fdata;
  logic [2:0][4:0]   r_faddr;
  logic [2:0]        r_used;
  logic              hazard;
  logic [31:0]       pending;

  int checks   = 0;
  int failures = 0;

  // Behavioural reference state.
  bit [31:0] m_pending;
  int        m_ptr;
  bit        m_we;
  int        m_waddr;
  bit [31:0] m_wdata;

  freg_wb_scheduler_if #(.N_REQ(N)) wb_if ();

  freg_wb_scheduler #(.N_REQ(N)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clk_en_i      (clk_en),
    .issue_valid_i (issue_valid),
    .issue_faddr_i (issue_faddr),
    .issue_ready_o (issue_ready),
    .wb            (wb_if.slave),
    .we_o          (we),
    .w_faddr_o     (w_faddr),
    .wr_fdata_o    (wr_fdata),
    .r_faddr_i     (r_faddr),
    .r_used_i      (r_used),
    .hazard_o      (hazard),
    .pending_o     (pending)
  );

  always #5 clk = ~clk;

  // Round-robin rule: first valid requester at or after ptr, wrapping.
  function automatic int m_grant(input logic [N-1:0] v, input int ptr);
    for (int off = 0; off < N; off++) begin
      if (v[(ptr + off) % N]) return (ptr + off) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    int g = m_grant(wb_if.req_valid, m_ptr);
    if (!clk_en || g < 0) return '0;
    return N'(1) << g;
  endfunction

  function automatic logic m_hazard();
    for (int p = 0; p < 3; p++)
      if (r_used[p] && m_pending[r_faddr[p]]) return 1'b1;
    return 1'b0;
  endfunction

  // Advance one clock and move the model to its post-edge state.
  task automatic tick();
    int        g;
    bit [31:0] np;
    @(posedge clk);
    g = m_grant(wb_if.req_valid, m_ptr);
    if (rst) begin
      m_pending = '0; m_ptr = 0; m_we = 0; m_waddr = 0; m_wdata = '0;
    end else if (clk_en) begin
      np = m_pending;
      if (m_we) np[m_waddr] = 1'b0;
      if (issue_valid && !m_pending[issue_faddr]) np[issue_faddr] = 1'b1;
      m_pending = np;
      if (g >= 0) begin
        m_we    = 1;
        m_waddr = int'(wb_if.req_faddr[g]);
        m_wdata = wb_if.req_data[g];
        m_ptr   = (g + 1) % N;
      end else begin
        m_we = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    clk_en            = 1'b1;
    issue_valid       = 1'b0;
    issue_faddr       = F0;
    wb_if.req_valid   = '0;
    wb_if.req_faddr   = '0;
    wb_if.req_data    = '0;
    r_faddr           = '0;
    r_used            = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    r_used  = 3'b111;
    r_faddr = {5'd3, 5'd2, 5'd1};
    #1;
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", we); end
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL reset_pending got=%h exp=0", pending); end
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%0b exp=0", hazard); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL reset_issue_ready got=%0b exp=1", issue_ready); end
    checks++; if (wb_if.req_ready !== '0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", wb_if.req_ready); end
    idle_inputs();
  endtask

  task automatic test_hazard_writeback();
    do_reset();
    issue_valid = 1'b1; issue_faddr = F5;
    #1;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL hz_issue_ready got=%0b exp=1", issue_ready); end
    tick();
    issue_valid = 1'b0;
    r_faddr[0] = 5'd5; r_used = 3'b001;
    wb_if.req_valid[2] = 1'b1; wb_if.req_faddr[2] = 5'd5; wb_if.req_data[2] = 32'h3F800000;
    #1;
    checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL hz_set got=%0b exp=1", hazard); end
    checks++; if (wb_if.req_ready !== 4'b0100) begin failures++; $display("FAIL hz_grant got=%b exp=0100", wb_if.req_ready); end
    tick();
    wb_if.req_valid = '0;
    #1;
    checks++; if (we !== 1'b1 || w_faddr !== F5 || wr_fdata !== 32'h3F800000) begin
      failures++; $display("FAIL hz_write got we=%0b a=%0d d=%h exp we=1 a=5 d=3f800000", we, w_faddr, wr_fdata);
    end
    checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL hz_during_write got=%0b exp=1", hazard); end
    tick();
    checks++; if (pending[5] !== 1'b0 || hazard !== 1'b0 || we !== 1'b0) begin
      failures++; $display("FAIL hz_clear got p5=%0b hz=%0b we=%0b exp 0 0 0", pending[5], hazard, we);
    end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) begin
      wb_if.req_faddr[i] = 5'(10 + i);
      wb_if.req_data[i]  = 32'hA000_0000 + i;
    end
    wb_if.req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++; if (wb_if.req_ready !== (N'(1) << (c % N))) begin
        failures++; $display("FAIL rr_grant c=%0d got=%b exp_idx=%0d", c, wb_if.req_ready, c % N);
      end
      if (c > 0) begin
        checks++; if (we !== 1'b1 || int'(w_faddr) != 10 + (c - 1) % N) begin
          failures++; $display("FAIL rr_write c=%0d got we=%0b a=%0d exp we=1 a=%0d", c, we, w_faddr, 10 + (c - 1) % N);
        end
      end
      tick();
    end
    wb_if.req_valid = '0;
    #1;
    checks++; if (we !== 1'b1 || w_faddr !== F13 || wr_fdata !== 32'hA000_0003) begin
      failures++; $display("FAIL rr_last got we=%0b a=%0d d=%h exp 1 13 a0000003", we, w_faddr, wr_fdata);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_set_wins();
    do_reset();
    issue_valid = 1'b1; issue_faddr = F7;
    tick();
    #1;
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL waw_stall got=%0b exp=0", issue_ready); end
    issue_valid = 1'b0;
    wb_if.req_valid[0] = 1'b1; wb_if.req_faddr[0] = 5'd7; wb_if.req_data[0] = 32'h1;
    tick();
    wb_if.req_valid = '0;
    tick();
    checks++; if (pending[7] !== 1'b0) begin failures++; $display("FAIL f7_retired got=%0b exp=0", pending[7]); end
    // Stray write to the now-free f7, and a fresh issue of f7 in its write cycle.
    wb_if.req_valid[1] = 1'b1; wb_if.req_faddr[1] = 5'd7; wb_if.req_data[1] = 32'h2;
    tick();
    wb_if.req_valid = '0;
    issue_valid = 1'b1; issue_faddr = F7;
    #1;
    checks++; if (we !== 1'b1 || w_faddr !== F7 || issue_ready !== 1'b1) begin
      failures++; $display("FAIL set_wins_setup got we=%0b a=%0d rdy=%0b exp 1 7 1", we, w_faddr, issue_ready);
    end
    tick();
    issue_valid = 1'b0;
    #1;
    checks++; if (pending[7] !== 1'b1) begin failures++; $display("FAIL set_wins got=%0b exp=1", pending[7]); end
    idle_inputs();
  endtask

  task automatic test_clk_en();
    do_reset();
    wb_if.req_valid[1] = 1'b1; wb_if.req_faddr[1] = 5'd21; wb_if.req_data[1] = 32'hCAFE;
    tick();
    wb_if.req_valid = '1;
    clk_en = 1'b0;
    issue_valid = 1'b1; issue_faddr = F3;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (wb_if.req_ready !== '0) begin failures++; $display("FAIL en_ready c=%0d got=%b exp=0", c, wb_if.req_ready); end
      checks++; if (we !== 1'b1 || w_faddr !== F21 || wr_fdata !== 32'hCAFE) begin
        failures++; $display("FAIL en_hold c=%0d got we=%0b a=%0d d=%h exp 1 21 cafe", c, we, w_faddr, wr_fdata);
      end
      tick();
      checks++; if (pending !== 32'h0) begin failures++; $display("FAIL en_pending c=%0d got=%h exp=0", c, pending); end
    end
    clk_en = 1'b1; issue_valid = 1'b0;
    #1;
    checks++; if (wb_if.req_ready !== 4'b0100) begin failures++; $display("FAIL en_resume got=%b exp=0100", wb_if.req_ready); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    for (int r = 8; r < 12; r++) begin
      issue_valid = 1'b1; issue_faddr = f_register_e'(r);
      tick();
    end
    issue_valid = 1'b0;
    wb_if.req_valid[2] = 1'b1; wb_if.req_faddr[2] = 5'd20; wb_if.req_data[2] = 32'h55;
    tick();
    wb_if.req_valid = '0;
    #1;
    checks++; if (we !== 1'b1 || pending !== 32'h0000_0F00) begin
      failures++; $display("FAIL rst_setup got we=%0b p=%h exp 1 00000f00", we, pending);
    end
    rst = 1'b1;
    wb_if.req_valid = '1; issue_valid = 1'b1; issue_faddr = F1;
    tick();
    rst = 1'b0; issue_valid = 1'b0;
    #1;
    checks++; if (we !== 1'b0 || pending !== 32'h0 || w_faddr !== F0 || wr_fdata !== 32'h0) begin
      failures++; $display("FAIL rst_inflight got we=%0b p=%h a=%0d d=%h exp all 0", we, pending, w_faddr, wr_fdata);
    end
    checks++; if (wb_if.req_ready !== 4'b0001) begin failures++; $display("FAIL rst_ptr got=%b exp=0001", wb_if.req_ready); end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    logic [N-1:0] granted;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom_range(63) == 0);
      clk_en      = ($urandom_range(7) != 0);
      issue_valid = $urandom_range(1);
      issue_faddr = f_register_e'($urandom_range(15));
      for (int p = 0; p < 3; p++) r_faddr[p] = 5'($urandom_range(15));
      r_used = 3'($urandom);
      #1;
      checks++; if (wb_if.req_ready !== m_ready()) begin
        failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, wb_if.req_ready, m_ready());
      end
      checks++; if (issue_ready !== !m_pending[issue_faddr]) begin
        failures++; $display("FAIL rnd_issue_ready c=%0d got=%0b exp=%0b", c, issue_ready, !m_pending[issue_faddr]);
      end
      checks++; if (hazard !== m_hazard()) begin
        failures++; $display("FAIL rnd_hazard c=%0d got=%0b exp=%0b", c, hazard, m_hazard());
      end
      checks++; if (pending !== m_pending) begin
        failures++; $display("FAIL rnd_pending c=%0d got=%h exp=%h", c, pending, m_pending);
      end
      checks++; if (we !== m_we || int'(w_faddr) != m_waddr || wr_fdata !== m_wdata) begin
        failures++; $display("FAIL rnd_write c=%0d got we=%0b a=%0d d=%h exp we=%0b a=%0d d=%h",
                             c, we, w_faddr, wr_fdata, m_we, m_waddr, m_wdata);
      end
      granted = m_ready();
      tick();
      // Requesters hold until granted, then may present a new request.
      for (int i = 0; i < N; i++) begin
        if (rst || !wb_if.req_valid[i] || granted[i]) begin
          wb_if.req_valid[i] = $urandom_range(1);
          wb_if.req_faddr[i] = 5'($urandom_range(15));
          wb_if.req_data[i]  = $urandom;
        end
      end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_pending = '0; m_ptr = 0; m_we = 0; m_waddr = 0; m_wdata = '0;
    test_reset();
    test_hazard_writeback();
    test_round_robin();
    test_set_wins();
    test_clk_en();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
